// File: rtl/bcd_scan_driver_if.sv
// Display-driver bus: binary load request in, multiplexed digit/select out.
// Latency: none, wiring only.
// Backpressure: busy tells the master that load strobes are being dropped.
interface bcd_scan_driver_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic [BIN_W-1:0]  bin_in;
  logic              load;
  logic              blank_lz;
  logic [DIGITS-1:0] dot_mask;
  logic              busy;
  logic              overflow;
  logic [3:0]        dig;
  logic              dot;
  logic [DIGITS-1:0] sel;

  modport master (
    output bin_in, load, blank_lz, dot_mask,
    input  busy, overflow, dig, dot, sel
  );

  modport slave (
    input  bin_in, load, blank_lz, dot_mask,
    output busy, overflow, dig, dot, sel
  );
endinterface

// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter (shift-add-3) feeding a multiplexed common-anode digit scanner.
// Latency: BIN_W+1 cycles from accepted load to new display; scan outputs are combinational.
// Backpressure: none queued; load is dropped while busy is high.
module bcd_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000
) (
  input logic              clk,
  input logic              rst,
  bcd_scan_driver_if.slave bus
);

  localparam int ACC_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int SCNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // Largest value that fits in DIGITS decimal digits; BIN_W is wide enough to hold it.
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(10**DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                 state;
  logic [BIN_W-1:0]       sr;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       adj;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   ovf_pend;
  logic                   busy_r;
  logic                   ovf_r;
  logic [DIGITS-1:0][3:0] disp;
  logic [SCNT_W-1:0]      scan_cnt;
  logic [IDX_W-1:0]       scan_idx;
  logic [DIGITS-1:0]      upper_zero;
  logic [DIGITS-1:0]      sel_n;
  logic [3:0]             cur_dig;
  logic                   cur_dot;
  logic                   cur_blank;

  // Add-3 correction: any BCD nibble >= 5 is bumped so the following shift carries correctly.
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: capture, BIN_W shift cycles, then one atomic commit to the display register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      busy_r   <= 1'b0;
      ovf_r    <= 1'b0;
      disp     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            sr       <= bus.bin_in;
            acc      <= '0;
            ovf_pend <= (bus.bin_in > MAX_VAL);
            bit_cnt  <= CNT_W'(BIN_W);
            busy_r   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Nibbles shifted out above DIGITS are lost; only matters on overflow, which blanks anyway.
          {acc, sr} <= {adj[ACC_W-2:0], sr, 1'b0};
          bit_cnt   <= bit_cnt - CNT_W'(1);
          if (bit_cnt == CNT_W'(1)) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          disp   <= ovf_pend ? {DIGITS{4'hF}} : acc;
          ovf_r  <= ovf_pend;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Free-running scan: hold each digit SCAN_DIV cycles, then step to the next, wrapping at DIGITS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      if (scan_idx == IDX_W'(DIGITS - 1)) begin
        scan_idx <= '0;
      end else begin
        scan_idx <= scan_idx + IDX_W'(1);
      end
    end else begin
      scan_cnt <= scan_cnt + SCNT_W'(1);
    end
  end

  // upper_zero[i] is set when display digits i..DIGITS-1 are all zero (leading-zero run).
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (disp[DIGITS-1] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (disp[i] == 4'h0);
    end
  end

  // Digit mux and select decode, driven only from the registered scan index so sel cannot glitch.
  always_comb begin
    sel_n     = '1;
    cur_dig   = 4'h0;
    cur_dot   = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        sel_n[i]  = 1'b0;
        cur_dig   = disp[i];
        cur_dot   = bus.dot_mask[i];
        // The rightmost digit always shows, so a value of zero reads "0".
        cur_blank = (i > 0) && upper_zero[i];
      end
    end
  end

  assign bus.sel      = sel_n;
  assign bus.dig      = (bus.blank_lz && cur_blank) ? 4'hF : cur_dig;
  assign bus.dot      = cur_dot;
  assign bus.busy     = busy_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Bench for bcd_scan_driver: directed steps then random loads against an arithmetic model.
// Latency: expects busy for BIN_W+1 cycles and the new display on the cycle after.
// Backpressure: exercises loads issued while busy, which must be dropped.
module tb_bcd_scan_driver;
  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;
  localparam int MAXV     = 9999;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_scan_driver_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_scan_driver #(
    .DIGITS  (DIGITS),
    .BIN_W   (BIN_W),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int ncmp = 0;
  int nfail = 0;
  int ncyc = 0;   // clock edges since the last reset edge
  int mval = 0;   // value the display should be showing
  bit movf = 1'b0;

  always @(posedge clk) begin
    if (rst) ncyc = 0;
    else     ncyc = ncyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [3:0] model_dig(input int idx);
    if (movf) return 4'hF;
    if (bus.blank_lz && idx > 0 && mval < pow10(idx)) return 4'hF;
    return 4'((mval / pow10(idx)) % 10);
  endfunction

  task automatic check_all(input string tag, input logic exp_busy);
    int idx;
    logic [DIGITS-1:0] esel;
    idx  = (ncyc / SCAN_DIV) % DIGITS;
    esel = '1;
    esel[idx] = 1'b0;
    chk({tag, "/sel"},  32'(bus.sel),      32'(esel));
    chk({tag, "/dig"},  32'(bus.dig),      32'(model_dig(idx)));
    chk({tag, "/dot"},  32'(bus.dot),      32'(bus.dot_mask[idx]));
    chk({tag, "/busy"}, 32'(bus.busy),     32'(exp_busy));
    chk({tag, "/ovf"},  32'(bus.overflow), 32'(movf));
  endtask

  task automatic run_checks(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      check_all(tag, 1'b0);
    end
  endtask

  // One accepted load; optionally a second strobe sampled second_at edges later, which must be dropped.
  task automatic do_load(input int val, input int second_at, input int second_val);
    bus.bin_in = BIN_W'(val);
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    check_all("load", 1'b1);
    for (int k = 1; k <= BIN_W; k++) begin
      if (k == second_at) begin
        bus.bin_in = BIN_W'(second_val);
        bus.load   = 1'b1;
      end
      tick();
      bus.load = 1'b0;
      check_all("busy", 1'b1);
    end
    tick();
    movf = (val > MAXV);
    mval = movf ? 0 : val;
    check_all("commit", 1'b0);
  endtask

  initial begin
    int v;
    int sa;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.bin_in   = '0;
    bus.blank_lz = 1'b0;
    bus.dot_mask = '0;
    tick();
    tick();
    check_all("reset", 1'b0);
    rst = 1'b0;
    run_checks(17, "scan");

    do_load(1234, -1, 0);
    run_checks(16, "v1234");

    bus.blank_lz = 1'b1;
    do_load(7, -1, 0);
    run_checks(16, "v7_blank");
    bus.blank_lz = 1'b0;
    run_checks(16, "v7_noblank");
    bus.blank_lz = 1'b1;
    do_load(0, -1, 0);
    run_checks(16, "v0_blank");

    bus.dot_mask = 4'b0100;
    do_load(12000, -1, 0);
    run_checks(16, "ovf");
    do_load(9999, -1, 0);
    run_checks(16, "v9999");

    do_load(42, 3, 99);
    run_checks(16, "ignored");

    // Reset asserted during the 6th shift cycle aborts the conversion.
    bus.bin_in = BIN_W'(5678);
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    check_all("abort_load", 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_all("abort_busy", 1'b1);
    end
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    mval = 0;
    movf = 1'b0;
    check_all("abort_rst", 1'b0);
    run_checks(3, "abort_idle");
    do_load(5678, -1, 0);
    run_checks(16, "v5678");

    for (int n = 0; n < 24; n++) begin
      v = int'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 120));
      bus.blank_lz = 1'($urandom_range(0, 1));
      bus.dot_mask = 4'($urandom);
      sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, BIN_W)) : -1;
      do_load(v, sa, int'($urandom_range(0, 16383)));
      run_checks(int'($urandom_range(4, 12)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
